// File: rtl/kernel_loader.sv
// kernel_loader: double-buffered assembler of KSIZE-coefficient convolution kernels from a word stream.
module kernel_loader #(
    parameter int NBITS = 20,
    parameter int KSIZE = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBITS-1:0]       in_data,
    input  logic                   in_last,
    output logic                   k_valid,
    input  logic                   k_ready,
    output logic [KSIZE*NBITS-1:0] k_data,
    output logic                   err_len,
    output logic [15:0]            kernel_count
);
    localparam int PW = $clog2(KSIZE);

    generate
        if (KSIZE != 9 && KSIZE != 25) begin : g_bad_ksize
            $error("kernel_loader: KSIZE must be 9 or 25");
        end
    endgenerate

    typedef enum logic {FILL, SKIP} state_t;

    state_t                 state;
    logic [KSIZE*NBITS-1:0] bank [2];
    logic [1:0]             full;
    logic                   wbank;
    logic                   rbank;
    logic [PW-1:0]          ptr;
    logic                   in_fire;
    logic                   out_fire;

    // Ready is held low throughout reset, even though the flags already read empty.
    assign in_ready = rst_n & ((state == SKIP) | ~full[wbank]);
    assign k_valid  = full[rbank];
    assign k_data   = bank[rbank];
    assign in_fire  = in_valid & in_ready;
    assign out_fire = k_valid & k_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FILL;
            bank[0]      <= '0;
            bank[1]      <= '0;
            full         <= '0;
            wbank        <= 1'b0;
            rbank        <= 1'b0;
            ptr          <= '0;
            err_len      <= 1'b0;
            kernel_count <= '0;
        end else begin
            err_len <= 1'b0;
            // A bank being read is full, a bank being written is not, so these never collide.
            if (out_fire) begin
                full[rbank]  <= 1'b0;
                rbank        <= ~rbank;
                kernel_count <= kernel_count + 16'd1;
            end
            if (in_fire) begin
                if (state == SKIP) begin
                    if (in_last)
                        state <= FILL;
                end else begin
                    bank[wbank][ptr*NBITS +: NBITS] <= in_data;
                    if (ptr == PW'(KSIZE-1)) begin
                        full[wbank] <= 1'b1;
                        wbank       <= ~wbank;
                        ptr         <= '0;
                        if (!in_last) begin
                            err_len <= 1'b1;
                            state   <= SKIP;
                        end
                    end else if (in_last) begin
                        ptr     <= '0;
                        err_len <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_kernel_loader.sv
// tb_kernel_loader: directed, table-driven and randomized checks of kernel_loader (KSIZE 9 and 25).
module tb_kernel_loader;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0, in_last = 0, k_ready = 0;
    logic [19:0]  in_data = 0;
    logic         in_ready, k_valid, err_len;
    logic [179:0] k_data;
    logic [15:0]  kernel_count;

    logic         in_valid25 = 0, in_last25 = 0, k_ready25 = 0;
    logic [19:0]  in_data25 = 0;
    logic         in_ready25, k_valid25, err_len25;
    logic [499:0] k_data25;
    logic [15:0]  kernel_count25;

    int checks = 0, errors = 0;
    int errs = 0;
    logic [179:0] got[$];

    kernel_loader #(.NBITS(20), .KSIZE(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
        .err_len(err_len), .kernel_count(kernel_count));

    kernel_loader #(.NBITS(20), .KSIZE(25)) dut25 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid25), .in_ready(in_ready25), .in_data(in_data25),
        .in_last(in_last25), .k_valid(k_valid25), .k_ready(k_ready25), .k_data(k_data25),
        .err_len(err_len25), .kernel_count(kernel_count25));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (k_valid && k_ready) got.push_back(k_data);
        if (err_len) errs++;
    end

    function automatic void chk(string n, logic [179:0] act, logic [179:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    function automatic logic [19:0] coef(logic [179:0] k, int i);
        return k[i*20 +: 20];
    endfunction

    task automatic do_reset();
        rst_n = 0; in_valid = 0; in_last = 0; k_ready = 0; in_valid25 = 0; k_ready25 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic put(input logic [19:0] d, input logic l);
        int t = 0;
        in_valid = 1; in_data = d; in_last = l;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (t == 100) chk("put_timeout", 0, 1);
        @(negedge clk);
        in_valid = 0; in_last = 0;
    endtask

    typedef struct {int len; int exp_err; int exp_cnt;} vec_t;

    initial begin
        vec_t vt[6];
        logic [179:0] q[$];
        logic [179:0] kb;
        bit   skip;
        int   cur_n, exp_cnt, glen, gi;
        logic exp_err;
        logic [19:0] cur_word;

        vt[0] = '{9, 0, 2};  vt[1] = '{4, 1, 1};  vt[2] = '{12, 1, 2};
        vt[3] = '{1, 1, 1};  vt[4] = '{8, 1, 1};  vt[5] = '{10, 1, 2};

        // reset state
        rst_n = 0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_k_valid", k_valid, 0);
        chk("rst_k_data", k_data, 0);
        chk("rst_err", err_len, 0);
        chk("rst_count", kernel_count, 0);
        do_reset();

        // basic load with latency
        for (int i = 1; i <= 8; i++) put(20'(i), 0);
        chk("basic_kvalid_early", k_valid, 0);
        put(20'd9, 1);
        chk("basic_kvalid", k_valid, 1);
        chk("basic_c0", coef(k_data, 0), 1);
        chk("basic_c8", coef(k_data, 8), 9);
        k_ready = 1;
        @(negedge clk);
        k_ready = 0;
        chk("basic_count", kernel_count, 1);
        chk("basic_kvalid_after", k_valid, 0);

        // double buffering / backpressure
        do_reset();
        for (int i = 1; i <= 9; i++) put(20'(i), i == 9);
        for (int i = 11; i <= 19; i++) put(20'(i), i == 19);
        chk("db_ready_low", in_ready, 0);
        repeat (5) @(negedge clk);
        chk("db_ready_hold", in_ready, 0);
        chk("db_stall_c0", coef(k_data, 0), 1);
        chk("db_stall_c8", coef(k_data, 8), 9);
        got.delete();
        k_ready = 1;
        @(negedge clk);
        chk("db_ready_after", in_ready, 1);
        chk("db_count1", kernel_count, 1);
        for (int i = 21; i <= 29; i++) put(20'(i), i == 29);
        repeat (3) @(negedge clk);
        chk("db_ndeliv", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            chk("db_order_c0", coef(got[i], 0), 20'(1 + 10*i));
            chk("db_order_c8", coef(got[i], 8), 20'(9 + 10*i));
        end
        chk("db_count3", kernel_count, 3);

        // table: malformed (or correct) kernel followed by a correct one
        foreach (vt[v]) begin
            do_reset();
            errs = 0; got.delete(); k_ready = 1;
            for (int i = 0; i < vt[v].len; i++) put(20'(i + 1), i == vt[v].len - 1);
            for (int i = 0; i < 9; i++) put(20'(100 + i), i == 8);
            repeat (3) @(negedge clk);
            chk("tbl_err", errs, vt[v].exp_err);
            chk("tbl_count", kernel_count, vt[v].exp_cnt);
            chk("tbl_ndeliv", got.size(), vt[v].exp_cnt);
            if (got.size() > 0) begin
                chk("tbl_last_c0", coef(got[got.size()-1], 0), 100);
                chk("tbl_last_c8", coef(got[got.size()-1], 8), 108);
                if (vt[v].exp_cnt == 2) chk("tbl_first_c8", coef(got[0], 8), 9);
            end
        end

        // reset mid-kernel
        do_reset();
        errs = 0; got.delete();
        for (int i = 1; i <= 5; i++) put(20'(50 + i), 0);
        rst_n = 0;
        #2;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_k_valid", k_valid, 0);
        chk("mid_rst_k_data", k_data, 0);
        chk("mid_rst_count", kernel_count, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        k_ready = 1;
        for (int i = 1; i <= 9; i++) put(20'(200 + i), i == 9);
        repeat (2) @(negedge clk);
        chk("mid_rst_ndeliv", got.size(), 1);
        if (got.size() > 0) chk("mid_rst_kernel", got[0][179:0],
            {20'd209, 20'd208, 20'd207, 20'd206, 20'd205, 20'd204, 20'd203, 20'd202, 20'd201});
        chk("mid_rst_err", errs, 0);

        // kernel_count wrap
        k_ready = 0;
        force dut9.kernel_count = 16'hFFFF;
        @(negedge clk);
        release dut9.kernel_count;
        @(negedge clk);
        chk("wrap_pre", kernel_count, 16'hFFFF);
        k_ready = 1;
        for (int i = 1; i <= 9; i++) put(20'(i), i == 9);
        repeat (2) @(negedge clk);
        chk("wrap_post", kernel_count, 0);

        // KSIZE=25 with negative coefficients
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            int t = 0;
            in_valid25 = 1; in_data25 = 20'(-i); in_last25 = (i == 25);
            while (!in_ready25 && t < 100) begin @(negedge clk); t++; end
            if (t == 100) chk("k25_timeout", 0, 1);
            if (i == 25) chk("k25_kvalid_early", k_valid25, 0);
            @(negedge clk);
        end
        in_valid25 = 0; in_last25 = 0;
        chk("k25_kvalid", k_valid25, 1);
        chk("k25_c24", k_data25[480 +: 20], 20'hFFFE7);
        chk("k25_c0", k_data25[0 +: 20], 20'hFFFFF);
        chk("k25_err", err_len25, 0);

        // randomized run against a kernel-queue reference model
        do_reset();
        q.delete(); skip = 0; cur_n = 0; exp_cnt = 0; exp_err = 0; kb = '0;
        glen = 9; gi = 0; cur_word = 20'($urandom);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit in_f, out_f;
            chk("rnd_in_ready", in_ready, skip || q.size() < 2);
            chk("rnd_k_valid", k_valid, q.size() > 0);
            if (q.size() > 0) chk("rnd_k_data", k_data, q[0]);
            chk("rnd_err", err_len, exp_err);
            chk("rnd_count", kernel_count, 16'(exp_cnt));
            in_valid = ($urandom_range(0, 9) < 8);
            in_data  = cur_word;
            in_last  = (gi == glen - 1);
            k_ready  = ($urandom_range(0, 9) < 6);
            in_f  = in_valid && (skip || q.size() < 2);
            out_f = k_ready && q.size() > 0;
            exp_err = 0;
            if (out_f) begin void'(q.pop_front()); exp_cnt++; end
            if (in_f) begin
                if (skip) begin
                    if (in_last) skip = 0;
                end else begin
                    kb[cur_n*20 +: 20] = in_data;
                    cur_n++;
                    if (cur_n == 9) begin
                        q.push_back(kb);
                        cur_n = 0;
                        if (!in_last) begin skip = 1; exp_err = 1; end
                    end else if (in_last) begin
                        cur_n = 0; exp_err = 1;
                    end
                end
                gi++;
                cur_word = 20'($urandom);
                if (gi == glen) begin
                    int r = $urandom_range(0, 19);
                    gi = 0;
                    glen = (r < 14) ? 9 : (r < 17) ? $urandom_range(1, 8) : $urandom_range(10, 13);
                end
            end
            @(negedge clk);
        end
        in_valid = 0; k_ready = 1;
        repeat (4) @(negedge clk);
        chk("rnd_drain_count", kernel_count, 16'(exp_cnt + q.size()));
        chk("rnd_drain_empty", k_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
